// File: rtl/valve_sequencer_pkg.sv
// Shared encodings for the valve sequencer: FSM states, latched irrigation mode
// and the busy decode used by the output logic.
package valve_sequencer_pkg;

   typedef enum logic [2:0] {
      S_OFF   = 3'd0,
      S_FILL  = 3'd1,
      S_PRIME = 3'd2,
      S_WATER = 3'd3,
      S_DEAD  = 3'd4,
      S_FAULT = 3'd5
   } state_t;

   typedef enum logic [0:0] {
      MODE_DRIP   = 1'b0,
      MODE_SPLINK = 1'b1
   } mode_t;

   function automatic logic is_busy(input state_t s);
      logic b;
      case (s)
         S_FILL, S_PRIME, S_WATER, S_DEAD: b = 1'b1;
         default:                          b = 1'b0;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/valve_sequencer_phase_timer.sv
// Loadable saturating up-counter with synchronous clear and a terminal compare
// against a caller-supplied value; shared by timed phases.
module valve_sequencer_phase_timer #(
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic [CNT_W-1:0] term_i,
   output logic             at_term_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Count register
   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Clear wins over load; counting stops at all-ones so it can never wrap
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (load_i) begin
         count_d = load_val_i;
      end else if (en_i && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + CNT_W'(1);
      end else begin
         count_d = count_q;
      end
   end

   assign at_term_o = (count_q == term_i);

endmodule

// File: rtl/valve_sequencer.sv
// Actuator sequencer for the tank loop: pump priming before irrigation valves,
// dead time after every active phase, fill watchdog and a sticky fault.
module valve_sequencer
   import valve_sequencer_pkg::*;
#(
   parameter int DEAD_TIME    = 4,
   parameter int PRIME_TIME   = 8,
   parameter int FILL_TIMEOUT = 1000,
   parameter int CNT_W        = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic watering,
   input  logic filling,
   input  logic dripper,
   input  logic splinker,
   input  logic fault_clear,
   output logic inlet_valve,
   output logic pump,
   output logic dripper_valve,
   output logic splinker_valve,
   output logic busy,
   output logic fault
);

   state_t           state_q;
   state_t           state_d;
   mode_t            mode_q;
   mode_t            mode_d;
   logic             timer_en_s;
   logic             timer_clr_s;
   logic             at_term_s;
   logic [CNT_W-1:0] term_s;

   // State and latched-mode registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_OFF;
         mode_q  <= MODE_DRIP;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
      end
   end

   // Next-state logic; in FILL the watering command can only be seen high after a
   // low-to-high change because OFF faults on both commands together
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      timer_en_s = 1'b0;
      case (state_q)
         S_OFF: begin
            if (watering && filling) begin
               state_d = S_FAULT;
            end else if (filling) begin
               state_d = S_FILL;
            end else if (watering) begin
               if (dripper ^ splinker) begin
                  state_d = S_PRIME;
                  mode_d  = dripper ? MODE_DRIP : MODE_SPLINK;
               end else begin
                  state_d = S_FAULT;
               end
            end else begin
               state_d = S_OFF;
            end
         end
         S_FILL: begin
            if (watering && filling) begin
               state_d = S_FAULT;
            end else if (!filling) begin
               state_d = S_DEAD;
            end else if (at_term_s) begin
               state_d = S_FAULT;
            end else begin
               timer_en_s = 1'b1;
            end
         end
         S_PRIME: begin
            if (!watering || filling) begin
               state_d = S_DEAD;
            end else if (at_term_s) begin
               state_d = S_WATER;
            end else begin
               timer_en_s = 1'b1;
            end
         end
         S_WATER: begin
            if (!watering || filling) begin
               state_d = S_DEAD;
            end else begin
               state_d = S_WATER;
            end
         end
         S_DEAD: begin
            if (at_term_s) begin
               state_d = S_OFF;
            end else begin
               timer_en_s = 1'b1;
            end
         end
         S_FAULT: begin
            if (fault_clear && !watering && !filling) begin
               state_d = S_OFF;
            end else begin
               state_d = S_FAULT;
            end
         end
         default: state_d = S_FAULT;
      endcase
   end

   // Terminal count for the phase currently running
   always_comb begin
      case (state_q)
         S_FILL:  term_s = CNT_W'(FILL_TIMEOUT - 1);
         S_PRIME: term_s = CNT_W'(PRIME_TIME - 1);
         S_DEAD:  term_s = CNT_W'(DEAD_TIME - 1);
         default: term_s = '0;
      endcase
   end

   assign timer_clr_s = (state_d != state_q);

   valve_sequencer_phase_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clock      (clock),
      .reset      (reset),
      .clr_i      (timer_clr_s),
      .en_i       (timer_en_s),
      .load_i     (1'b0),
      .load_val_i ({CNT_W{1'b0}}),
      .term_i     (term_s),
      .at_term_o  (at_term_s)
   );

   // Moore output decode of the state register
   always_comb begin
      inlet_valve    = 1'b0;
      pump           = 1'b0;
      dripper_valve  = 1'b0;
      splinker_valve = 1'b0;
      fault          = 1'b0;
      busy           = is_busy(state_q);
      case (state_q)
         S_FILL:  inlet_valve = 1'b1;
         S_PRIME: pump = 1'b1;
         S_WATER: begin
            pump           = 1'b1;
            dripper_valve  = (mode_q == MODE_DRIP);
            splinker_valve = (mode_q == MODE_SPLINK);
         end
         S_FAULT: fault = 1'b1;
         default: inlet_valve = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_valve_sequencer.sv
// Directed bench for valve_sequencer: expected output vectors are queued as each
// cycle's stimulus is driven and checked one edge later.
module tb_valve_sequencer;

   logic clock = 1'b0;
   logic reset, watering, filling, dripper, splinker, fault_clear;
   logic inlet_valve, pump, dripper_valve, splinker_valve, busy, fault;

   int tests = 0;
   int fails = 0;
   logic [5:0] sb_q[$];

   // {inlet, pump, dripper_valve, splinker_valve, busy, fault}
   localparam logic [5:0] E_OFF   = 6'b000000;
   localparam logic [5:0] E_FILL  = 6'b100010;
   localparam logic [5:0] E_PRIME = 6'b010010;
   localparam logic [5:0] E_WDRIP = 6'b011010;
   localparam logic [5:0] E_WSPL  = 6'b010110;
   localparam logic [5:0] E_DEAD  = 6'b000010;
   localparam logic [5:0] E_FAULT = 6'b000001;

   always #5 clock = ~clock;

   valve_sequencer #(
      .DEAD_TIME    (4),
      .PRIME_TIME   (8),
      .FILL_TIMEOUT (1000),
      .CNT_W        (16)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .watering       (watering),
      .filling        (filling),
      .dripper        (dripper),
      .splinker       (splinker),
      .fault_clear    (fault_clear),
      .inlet_valve    (inlet_valve),
      .pump           (pump),
      .dripper_valve  (dripper_valve),
      .splinker_valve (splinker_valve),
      .busy           (busy),
      .fault          (fault)
   );

   task automatic cyc(input logic w, input logic f, input logic d, input logic s,
                      input logic fc, input logic r, input logic [5:0] exp,
                      input string tag);
      logic [5:0] obs;
      logic [5:0] want;
      watering    = w;
      filling     = f;
      dripper     = d;
      splinker    = s;
      fault_clear = fc;
      reset       = r;
      sb_q.push_back(exp);
      @(posedge clock);
      #1;
      obs  = {inlet_valve, pump, dripper_valve, splinker_valve, busy, fault};
      want = sb_q.pop_front();
      tests++;
      assert (obs === want) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, want);
      end
      tests++;
      assert (!(obs[5] && (obs[4] || obs[3] || obs[2]))) else begin
         fails++;
         $error("FAIL %s_overlap: observed %b expected no inlet/irrigation overlap", tag, obs);
      end
   endtask

   task automatic run(input int n, input logic w, input logic f, input logic d,
                      input logic s, input logic fc, input logic r,
                      input logic [5:0] exp, input string tag);
      for (int i = 0; i < n; i++) begin
         cyc(w, f, d, s, fc, r, exp, tag);
      end
   endtask

   initial begin
      #1;
      // reset and idle
      run(2, 0, 0, 0, 0, 0, 1, E_OFF, "reset");
      run(2, 0, 0, 0, 0, 0, 0, E_OFF, "idle");

      // fill for 20 cycles, then dead time
      run(20, 0, 1, 0, 0, 0, 0, E_FILL, "fill20");
      run(4, 0, 0, 0, 0, 0, 0, E_DEAD, "fill_dead");
      run(2, 0, 0, 0, 0, 0, 0, E_OFF, "fill_off");

      // dripper watering with priming; splinker toggle ignored in WATER
      run(8, 1, 0, 1, 0, 0, 0, E_PRIME, "drip_prime");
      run(3, 1, 0, 1, 0, 0, 0, E_WDRIP, "drip_water");
      run(3, 1, 0, 0, 1, 0, 0, E_WDRIP, "drip_mode_hold");
      run(4, 0, 0, 0, 0, 0, 0, E_DEAD, "drip_dead");
      run(1, 0, 0, 0, 0, 0, 0, E_OFF, "drip_off");

      // both modes selected -> fault; clear ignored while watering high
      run(2, 1, 0, 1, 1, 0, 0, E_FAULT, "both_mode_fault");
      run(1, 1, 0, 0, 0, 1, 0, E_FAULT, "clear_ignored");
      run(1, 0, 0, 0, 0, 0, 0, E_FAULT, "fault_sticky");
      run(1, 0, 0, 0, 0, 1, 0, E_OFF, "fault_cleared");
      run(1, 0, 0, 0, 0, 0, 0, E_OFF, "post_clear");

      // no mode selected, and both commands together -> fault
      run(1, 1, 0, 0, 0, 0, 0, E_FAULT, "no_mode_fault");
      run(1, 0, 0, 0, 0, 1, 0, E_OFF, "no_mode_clear");
      run(1, 1, 1, 1, 0, 0, 0, E_FAULT, "both_cmd_fault");
      run(1, 0, 1, 0, 0, 1, 0, E_FAULT, "clear_fill_high");
      run(1, 0, 0, 0, 0, 1, 0, E_OFF, "both_cmd_clear");

      // watering rises during FILL -> fault
      run(3, 0, 1, 0, 0, 0, 0, E_FILL, "fill_pre");
      run(1, 1, 1, 1, 0, 0, 0, E_FAULT, "fill_water_fault");
      run(1, 0, 0, 0, 0, 1, 0, E_OFF, "fill_water_clear");

      // splinker watering, then filling request from WATER
      run(8, 1, 0, 0, 1, 0, 0, E_PRIME, "spl_prime");
      run(2, 1, 0, 0, 1, 0, 0, E_WSPL, "spl_water");
      run(2, 1, 0, 1, 0, 0, 0, E_WSPL, "spl_mode_hold");
      run(4, 0, 1, 0, 0, 0, 0, E_DEAD, "water_to_fill_dead");
      run(1, 0, 1, 0, 0, 0, 0, E_OFF, "water_to_fill_off");
      run(3, 0, 1, 0, 0, 0, 0, E_FILL, "water_to_fill");
      run(4, 0, 0, 0, 0, 0, 0, E_DEAD, "fill2_dead");
      run(1, 0, 0, 0, 0, 0, 0, E_OFF, "fill2_off");

      // watering dropped during PRIME -> dead time
      run(3, 1, 0, 1, 0, 0, 0, E_PRIME, "prime_abort");
      run(4, 0, 0, 0, 0, 0, 0, E_DEAD, "prime_abort_dead");
      run(1, 0, 0, 0, 0, 0, 0, E_OFF, "prime_abort_off");

      // fill watchdog
      run(1000, 0, 1, 0, 0, 0, 0, E_FILL, "fill_timeout_run");
      run(2, 0, 1, 0, 0, 0, 0, E_FAULT, "fill_timeout_fault");
      run(1, 0, 0, 0, 0, 1, 0, E_OFF, "fill_timeout_clear");

      // reset during PRIME, and reset clearing a fault
      run(3, 1, 0, 1, 0, 0, 0, E_PRIME, "rst_prime");
      run(1, 1, 0, 1, 0, 0, 1, E_OFF, "rst_in_prime");
      run(1, 0, 0, 0, 0, 0, 0, E_OFF, "rst_prime_after");
      run(1, 1, 0, 0, 0, 0, 0, E_FAULT, "rst_fault_pre");
      run(1, 0, 0, 0, 0, 0, 1, E_OFF, "rst_in_fault");
      run(2, 0, 0, 0, 0, 0, 0, E_OFF, "final_idle");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
